pwm_gate_driver: RTL and testbench

- Downstream stage of the delta-sigma modulator.
- Consumes the modulator's 2-bit three-level symbol stream and drives the four gates of a full H-bridge (legs A and B).
- Inserts programmable dead time on every gate handover, handles enable and a latched fault, and guarantees that high and low gates of one leg are never on together.

---
 rtl/pwm_gate_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_pwm_gate_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_gate_driver.sv
// rtl/pwm_gate_driver.sv - dead-time H-bridge gate driver for a three-level delta-sigma symbol stream
//
// Purpose:
//   Registers the modulator's 2-bit symbol and drives the four gates of a full
//   H-bridge. Each leg runs a small FSM (OFF / DEAD / LO_ON / HI_ON) that
//   keeps both gates of the leg off for DEAD_CYCLES clocks on every handover.
//   Disable and fault turn the bridge off at the next edge with no dead time.
//   The fault flag is sticky until cleared.
//
// Optional feature (macro DRV_MIN_ON_EN):
//   Defined   - each leg must stay in LO_ON or HI_ON for MIN_ON_CYCLES clocks
//               before a target change can start a handover.
//   Undefined - a target change leaves LO_ON / HI_ON at the next edge, and
//               MIN_ON_CYCLES has no effect.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   en_i         bridge enable
//   pwm_i        symbol: 00 zero, 01 positive, 10 negative, 11 invalid
//   fault_i      external fault, synchronous level
//   fault_clr_i  clears the latched fault when fault_i is low
//   a_hi_o/a_lo_o, b_hi_o/b_lo_o  gate drives for legs A and B
//   fault_o      sticky fault flag
//   invalid_o    one-cycle pulse after a symbol 11 is captured
//   busy_o       either leg is in its dead time

module pwm_gate_driver #(
    parameter int unsigned DEAD_CYCLES   = 3,
    parameter int unsigned MIN_ON_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] pwm_i,
    input  logic       fault_i,
    input  logic       fault_clr_i,
    output logic       a_hi_o,
    output logic       a_lo_o,
    output logic       b_hi_o,
    output logic       b_lo_o,
    output logic       fault_o,
    output logic       invalid_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_LO_ON = 2'd2,
        ST_HI_ON = 2'd3
    } leg_state_t;

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_bad_dead
        $error("DEAD_CYCLES must be in 1..15");
    end
    if (MIN_ON_CYCLES < 1 || MIN_ON_CYCLES > 15) begin : g_bad_min_on
        $error("MIN_ON_CYCLES must be in 1..15");
    end

    // The dead counter counts down to zero, so DEAD_CYCLES-1 gives exactly
    // DEAD_CYCLES clocks in DEAD.
    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    logic [1:0] sym_r;
    logic       fault_r;
    logic       invalid_r;
    logic       busy_r;

    // Symbol 11 is stored as zero so the legs never see it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sym_r     <= 2'b00;
            invalid_r <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            sym_r     <= (pwm_i == 2'b11) ? 2'b00 : pwm_i;
            invalid_r <= (pwm_i == 2'b11);
            if (fault_i) begin
                fault_r <= 1'b1;
            end else if (fault_clr_i) begin
                fault_r <= 1'b0;
            end
        end
    end

    // Bit 0 is leg A, bit 1 is leg B.
    logic [1:0] tgt;
    assign tgt[0] = (sym_r == 2'b01);
    assign tgt[1] = (sym_r == 2'b10);

    // A raw fault_i turns the legs off at the same edge that latches fault_r.
    logic off_req;
    assign off_req = !en_i || fault_r || fault_i;

    logic [1:0] leg_hi;
    logic [1:0] leg_lo;
    logic [1:0] leg_dead_d;

    for (genvar g = 0; g < 2; g++) begin : g_leg
        leg_state_t state_q;
        leg_state_t state_d;
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;
        logic       hi_q;
        logic       lo_q;
        logic       hi_d;
        logic       lo_d;
        logic       leave_ok;

`ifdef DRV_MIN_ON_EN
        localparam logic [3:0] MIN_ON_LAST = 4'(MIN_ON_CYCLES - 1);
        logic [3:0] on_q;
        logic [3:0] on_d;

        // Restarts whenever the state changes, so it measures time spent in
        // the current LO_ON / HI_ON state.
        always_comb begin
            on_d = on_q;
            if (state_d != state_q) begin
                on_d = 4'd0;
            end else if (on_q != 4'hF) begin
                on_d = on_q + 4'd1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                on_q <= 4'd0;
            end else begin
                on_q <= on_d;
            end
        end

        assign leave_ok = (on_q >= MIN_ON_LAST);
`else
        assign leave_ok = 1'b1;
`endif

        // State register, with the gate outputs registered from the next state.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= ST_OFF;
                cnt_q   <= 4'd0;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hi_q    <= hi_d;
                lo_q    <= lo_d;
            end
        end

        // Next-state logic. The target is sampled only when the dead time
        // expires, so a short glitch returns the leg to its original side.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (off_req) begin
                state_d = ST_OFF;
                cnt_d   = 4'd0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                    ST_DEAD: begin
                        if (cnt_q == 4'd0) begin
                            state_d = tgt[g] ? ST_HI_ON : ST_LO_ON;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    ST_LO_ON: begin
                        if (tgt[g] && leave_ok) begin
                            state_d = ST_DEAD;
                            cnt_d   = DEAD_LOAD;
                        end
                    end
                    ST_HI_ON: begin
                        if (!tgt[g] && leave_ok) begin
                            state_d = ST_DEAD;
                            cnt_d   = DEAD_LOAD;
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                        cnt_d   = 4'd0;
                    end
                endcase
            end
        end

        // Output decode. hi and lo come from mutually exclusive states, so
        // they can never be on together.
        always_comb begin
            hi_d = (state_d == ST_HI_ON);
            lo_d = (state_d == ST_LO_ON);
        end

        assign leg_hi[g]     = hi_q;
        assign leg_lo[g]     = lo_q;
        assign leg_dead_d[g] = (state_d == ST_DEAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |leg_dead_d;
        end
    end

    assign a_hi_o    = leg_hi[0];
    assign a_lo_o    = leg_lo[0];
    assign b_hi_o    = leg_hi[1];
    assign b_lo_o    = leg_lo[1];
    assign fault_o   = fault_r;
    assign invalid_o = invalid_r;
    assign busy_o    = busy_r;

endmodule

// File: tb/tb_pwm_gate_driver.sv
// tb/tb_pwm_gate_driver.sv - directed self-checking bench for pwm_gate_driver
//
// Purpose: drives hand-computed directed steps with DEAD_CYCLES = 3 and checks
// gates, fault, invalid and busy after every step.
// Observed vector layout: {a_hi, a_lo, b_hi, b_lo, fault, invalid, busy}.
// Build with DRV_MIN_ON_EN defined to run the minimum on-time step instead of
// the default handover steps.

module tb_pwm_gate_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic       en_i;
    logic [1:0] pwm_i;
    logic       fault_i;
    logic       fault_clr_i;
    logic       a_hi_o;
    logic       a_lo_o;
    logic       b_hi_o;
    logic       b_lo_o;
    logic       fault_o;
    logic       invalid_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit inv_on   = 1'b0;

    pwm_gate_driver #(
        .DEAD_CYCLES   (3),
        .MIN_ON_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en_i        (en_i),
        .pwm_i       (pwm_i),
        .fault_i     (fault_i),
        .fault_clr_i (fault_clr_i),
        .a_hi_o      (a_hi_o),
        .a_lo_o      (a_lo_o),
        .b_hi_o      (b_hi_o),
        .b_lo_o      (b_lo_o),
        .fault_o     (fault_o),
        .invalid_o   (invalid_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] obs();
        return {a_hi_o, a_lo_o, b_hi_o, b_lo_o, fault_o, invalid_o, busy_o};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] o;
        o = obs();
        n_checks++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, exp);
        end
    endtask

    // Same-leg overlap must never happen, checked every cycle once out of reset.
    always @(negedge clock) begin
        if (inv_on) begin
            n_checks++;
            assert (((a_hi_o & a_lo_o) | (b_hi_o & b_lo_o)) === 1'b0) else begin
                n_fail++;
                $error("FAIL overlap: observed a=%b%b b=%b%b expected no same-leg overlap",
                       a_hi_o, a_lo_o, b_hi_o, b_lo_o);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        en_i        = 1'b0;
        pwm_i       = 2'b00;
        fault_i     = 1'b0;
        fault_clr_i = 1'b0;
        tick(2);
        chk("reset", 7'b0000_000);
        inv_on = 1'b1;

        // Reset release with zero symbol: three dead cycles, then both lows.
        reset = 1'b0;
        en_i  = 1'b1;
        tick(1); chk("start_dead1", 7'b0000_001);
        tick(1); chk("start_dead2", 7'b0000_001);
        tick(1); chk("start_dead3", 7'b0000_001);
        tick(1); chk("start_lo",    7'b0101_000);

`ifdef DRV_MIN_ON_EN
        // 01 captured one cycle after LO_ON entry waits until four cycles in LO_ON.
        pwm_i = 2'b01;
        tick(1); chk("minon_hold1", 7'b0101_000);
        tick(1); chk("minon_hold2", 7'b0101_000);
        tick(1); chk("minon_hold3", 7'b0101_000);
        tick(1); chk("minon_leave", 7'b0001_001);
        tick(1); chk("minon_dead2", 7'b0001_001);
        tick(1); chk("minon_dead3", 7'b0001_001);
        tick(1); chk("minon_hi",    7'b1001_000);
`else
        // 00 -> 01: a_lo falls at k+1, a_hi rises at k+4.
        pwm_i = 2'b01;
        tick(1); chk("pos_capture", 7'b0101_000);
        tick(1); chk("pos_dead1",   7'b0001_001);
        tick(1); chk("pos_dead2",   7'b0001_001);
        tick(1); chk("pos_dead3",   7'b0001_001);
        tick(1); chk("pos_hi",      7'b1001_000);

        // 01 -> 10: both legs hand over together.
        pwm_i = 2'b10;
        tick(1); chk("neg_capture", 7'b1001_000);
        tick(1); chk("neg_dead1",   7'b0000_001);
        tick(1); chk("neg_dead2",   7'b0000_001);
        tick(1); chk("neg_dead3",   7'b0000_001);
        tick(1); chk("neg_on",      7'b0110_000);

        // Back to zero.
        pwm_i = 2'b00;
        tick(5); chk("zero_again",  7'b0101_000);

        // Single-cycle 01 glitch: leg A returns to LO_ON, a_hi never rises.
        pwm_i = 2'b01;
        tick(1); chk("glitch_capture", 7'b0101_000);
        pwm_i = 2'b00;
        tick(1); chk("glitch_dead1",   7'b0001_001);
        tick(1); chk("glitch_dead2",   7'b0001_001);
        tick(1); chk("glitch_dead3",   7'b0001_001);
        tick(1); chk("glitch_back_lo", 7'b0101_000);

        // Fault during HI_ON.
        pwm_i = 2'b01;
        tick(5); chk("pre_fault_hi", 7'b1001_000);
        fault_i = 1'b1;
        tick(1); chk("fault_off",    7'b0000_100);
        fault_clr_i = 1'b1;
        tick(1); chk("fault_wins",   7'b0000_100);
        fault_i = 1'b0;
        tick(1); chk("fault_clear",  7'b0000_000);
        fault_clr_i = 1'b0;
        tick(1); chk("clr_dead1",    7'b0000_001);
        tick(1); chk("clr_dead2",    7'b0000_001);
        tick(1); chk("clr_dead3",    7'b0000_001);
        tick(1); chk("clr_target",   7'b1001_000);

        // Symbol 11 for one cycle: invalid pulse, treated as zero.
        pwm_i = 2'b11;
        tick(1); chk("inv_pulse",    7'b1001_010);
        pwm_i = 2'b01;
        tick(1); chk("inv_as_zero",  7'b0001_001);
        tick(1); chk("inv_dead2",    7'b0001_001);
        tick(1); chk("inv_dead3",    7'b0001_001);
        tick(1); chk("inv_recover",  7'b1001_000);

        // Disable turns off at the next edge without dead time.
        en_i = 1'b0;
        tick(1); chk("disable_off",  7'b0000_000);
        en_i = 1'b1;
        tick(1); chk("reenable_dead", 7'b0000_001);
        tick(3); chk("reenable_hi",  7'b1001_000);

        // Reset mid-operation forces gates low at the next edge.
        reset = 1'b1;
        tick(1); chk("mid_reset",    7'b0000_000);
        reset = 1'b0;
        tick(1); chk("post_reset_dead", 7'b0000_001);
`endif

        inv_on = 1'b0;
        tick(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
